spn_round_ctrl: RTL and testbench

SPN_ROUND_CTRL -- requirements
Module: spn_round_ctrl

---
 rtl/spn_round_ctrl_if.sv | 25 ++
 rtl/spn_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_spn_round_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spn_round_ctrl_if.sv
// Request/result bundle for spn_round_ctrl.
// The requester drives the block inputs and out_ready.
// The cipher controller drives the ready, result and status signals.
interface spn_round_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [15:0] in_data;
   logic [31:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;
   logic [2:0]  round_o;

   modport master (
      output in_valid, in_mode, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data, busy, round_o
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data, busy, round_o
   );
endinterface

// File: rtl/spn_round_ctrl.sv
// Four-round 16-bit SPN cipher controller with a 32-bit key.
// Each round takes one clock, so a result appears four clocks after accept.
// The result is held in DONE until the consumer takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; out_data forced to zero
// S_RUN  | one round per clock, r_round = 1..4
// S_DONE | result valid in r_x, waiting for out_ready
module spn_round_ctrl (
   input  logic          clk,
   input  logic          rst_n,
   spn_round_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_round, w_round_nxt;
   logic [15:0] r_x, w_x_nxt;
   logic [31:0] r_key, w_key_nxt;
   logic        r_mode, w_mode_nxt;
   logic [15:0] w_round_out;

   // Round key r is the 16-bit window starting 4r bits below the key MSB.
   function automatic logic [15:0] rk(input logic [31:0] k, input logic [2:0] r);
      logic [15:0] v;
      case (r)
         3'd0:    v = k[31:16];
         3'd1:    v = k[27:12];
         3'd2:    v = k[23:8];
         3'd3:    v = k[19:4];
         3'd4:    v = k[15:0];
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] v;
      case (n)
         4'h0: v = 4'hA;  4'h1: v = 4'h5;  4'h2: v = 4'h8;  4'h3: v = 4'h2;
         4'h4: v = 4'h6;  4'h5: v = 4'hC;  4'h6: v = 4'h4;  4'h7: v = 4'h3;
         4'h8: v = 4'h1;  4'h9: v = 4'h0;  4'hA: v = 4'hB;  4'hB: v = 4'h9;
         4'hC: v = 4'hF;  4'hD: v = 4'hD;  4'hE: v = 4'h7;  default: v = 4'hE;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] n);
      logic [3:0] v;
      case (n)
         4'h0: v = 4'h9;  4'h1: v = 4'h8;  4'h2: v = 4'h3;  4'h3: v = 4'h7;
         4'h4: v = 4'h6;  4'h5: v = 4'h1;  4'h6: v = 4'h4;  4'h7: v = 4'hE;
         4'h8: v = 4'h2;  4'h9: v = 4'hB;  4'hA: v = 4'h0;  4'hB: v = 4'hA;
         4'hC: v = 4'h5;  4'hD: v = 4'hD;  4'hE: v = 4'hF;  default: v = 4'hC;
      endcase
      return v;
   endfunction

   function automatic logic [15:0] sub(input logic [15:0] x, input logic inv);
      logic [15:0] v;
      for (int n = 0; n < 4; n++)
         v[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox(x[4*n +: 4]);
      return v;
   endfunction

   // 4x4 bit-matrix transpose; its own inverse.
   function automatic logic [15:0] perm(input logic [15:0] x);
      logic [15:0] v;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            v[4*b + a] = x[4*a + b];
      return v;
   endfunction

   // Round datapath: one encrypt or decrypt round selected by r_mode/r_round.
   always_comb begin
      w_round_out = 16'h0000;
      if (!r_mode) begin
         if (r_round == 3'd4)
            w_round_out = sub(r_x ^ rk(r_key, 3'd3), 1'b0) ^ rk(r_key, 3'd4);
         else
            w_round_out = perm(sub(r_x ^ rk(r_key, r_round - 3'd1), 1'b0));
      end else begin
         if (r_round == 3'd1)
            w_round_out = sub(r_x ^ rk(r_key, 3'd4), 1'b1) ^ rk(r_key, 3'd3);
         else
            w_round_out = sub(perm(r_x), 1'b1) ^ rk(r_key, 3'd4 - r_round);
      end
   end

   // Next-state logic; operands are captured only on accept in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_x_nxt     = r_x;
      w_key_nxt   = r_key;
      w_mode_nxt  = r_mode;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = S_RUN;
               w_round_nxt = 3'd1;
               w_x_nxt     = bus.in_data;
               w_key_nxt   = bus.in_key;
               w_mode_nxt  = bus.in_mode;
            end
         end
         S_RUN: begin
            w_x_nxt = w_round_out;
            if (r_round == 3'd4)
               w_state_nxt = S_DONE;
            else
               w_round_nxt = r_round + 3'd1;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
               w_round_nxt = 3'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 3'd0;
         end
      endcase
   end

   // State and datapath registers; reset discards any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_round <= 3'd0;
         r_x     <= 16'h0000;
         r_key   <= 32'h0000_0000;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_x     <= w_x_nxt;
         r_key   <= w_key_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign bus.round_o   = r_round;
   assign bus.out_data  = (r_state == S_DONE) ? r_x : 16'h0000;
endmodule

// File: tb/tb_spn_round_ctrl.sv
// Bench for spn_round_ctrl: directed vectors, back-pressure, input toggling,
// reset in RUN/DONE and random encrypt/decrypt round trips against a model.
module tb_spn_round_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   spn_round_ctrl_if bus();
   spn_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   int n_hs    = 0;

   bit [3:0] sbox_tab [16] = '{4'hA, 4'h5, 4'h8, 4'h2, 4'h6, 4'hC, 4'h4, 4'h3,
                               4'h1, 4'h0, 4'hB, 4'h9, 4'hF, 4'hD, 4'h7, 4'hE};
   bit [3:0] sinv_tab [16];

   // ---------------- reference model ----------------
   function automatic bit [15:0] m_rk(bit [31:0] k, int r);
      return 16'(k >> (16 - 4*r));
   endfunction

   function automatic bit [15:0] m_sub(bit [15:0] x, bit inv);
      bit [15:0] v = 0;
      for (int n = 0; n < 4; n++) begin
         int nib = (x >> (4*n)) & 15;
         v = v | (16'(inv ? sinv_tab[nib] : sbox_tab[nib]) << (4*n));
      end
      return v;
   endfunction

   function automatic bit [15:0] m_perm(bit [15:0] x);
      bit [15:0] v = 0;
      for (int i = 0; i < 16; i++)
         v[4*(i%4) + i/4] = x[i];
      return v;
   endfunction

   function automatic bit [15:0] m_enc(bit [15:0] p, bit [31:0] k);
      bit [15:0] x = p;
      for (int r = 1; r <= 3; r++) x = m_perm(m_sub(x ^ m_rk(k, r-1), 0));
      return m_sub(x ^ m_rk(k, 3), 0) ^ m_rk(k, 4);
   endfunction

   function automatic bit [15:0] m_dec(bit [15:0] c, bit [31:0] k);
      bit [15:0] x = m_sub(c ^ m_rk(k, 4), 1) ^ m_rk(k, 3);
      for (int r = 2; r <= 4; r++) x = m_sub(m_perm(x), 1) ^ m_rk(k, 4-r);
      return x;
   endfunction

   // ---------------- stimulus helpers (no checks) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit mode, input bit [15:0] data, input bit [31:0] key, output bit ok);
      int n = 0;
      while (!bus.in_ready && n < 20) begin tick(); n++; end
      ok = bus.in_ready;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
         return;
      end
      bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_data = data; bus.in_key = key;
      tick();
      bus.in_valid = 1'b0;
      n_acc++;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin tick(); cyc++; end
   endtask

   task automatic run_one(input bit mode, input bit [15:0] data, input bit [31:0] key,
                          output bit [15:0] got, output bit ok);
      bit sent;
      ok = 1'b0; got = 16'h0;
      send(mode, data, key, sent);
      if (!sent) return;
      for (int i = 0; i < 40 && !ok; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (bus.out_valid && bus.out_ready) begin got = bus.out_data; ok = 1'b1; n_hs++; end
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.in_valid = 0; bus.in_mode = 0; bus.in_data = 0; bus.in_key = 0; bus.out_ready = 1;
      #12;
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      n_tests++; if (bus.round_o !== 3'd0) begin n_fail++; $display("FAIL rst_round got %0d exp 0", bus.round_o); end
      n_tests++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data got %h exp 0000", bus.out_data); end
      // first accept on the first edge after release
      bus.in_valid = 1'b1;
      #11 rst_n = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_acc++;
      n_tests++; if (bus.round_o !== 3'd1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_accept round=%0d busy=%b exp 1/1", bus.round_o, bus.busy); end
      repeat (6) tick();
      n_hs++;
   endtask

   task automatic test_enc_vector();
      bit ok;
      bus.out_ready = 1'b1;
      send(0, 16'h0000, 32'h0, ok);
      for (int r = 1; r <= 4; r++) begin
         n_tests++; if (bus.round_o !== 3'(r)) begin n_fail++; $display("FAIL enc_round got %0d exp %0d", bus.round_o, r); end
         n_tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0)
            begin n_fail++; $display("FAIL enc_run_outs r=%0d valid=%b busy=%b ready=%b data=%h exp 0/1/0/0000", r, bus.out_valid, bus.busy, bus.in_ready, bus.out_data); end
         tick();
      end
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL enc_latency out_valid got %b exp 1", bus.out_valid); end
      n_tests++; if (bus.out_data !== 16'hEBE6) begin n_fail++; $display("FAIL enc_vector got %h exp EBE6", bus.out_data); end
      n_tests++; if (bus.round_o !== 3'd4) begin n_fail++; $display("FAIL done_round got %0d exp 4", bus.round_o); end
      tick();
      n_hs++;
      n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round_o !== 3'd0)
         begin n_fail++; $display("FAIL back_to_idle ready=%b valid=%b busy=%b round=%0d exp 1/0/0/0", bus.in_ready, bus.out_valid, bus.busy, bus.round_o); end
   endtask

   task automatic test_dec_vector();
      bit ok; int cyc;
      send(1, 16'hEBE6, 32'h0, ok);
      wait_valid(cyc);
      n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL dec_latency got %0d exp 4", cyc); end
      n_tests++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL dec_vector got %h exp 0000", bus.out_data); end
      tick();
      n_hs++;
   endtask

   task automatic test_backpressure();
      bit ok; int cyc; bit [15:0] p = 16'($urandom); bit [31:0] k = $urandom; bit [15:0] exp_d;
      exp_d = m_enc(p, k);
      bus.out_ready = 1'b0;
      send(0, p, k, ok);
      wait_valid(cyc);
      n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL bp_latency got %0d exp 4", cyc); end
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = 16'($urandom); bus.in_key = $urandom;
         tick();
         n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.round_o !== 3'd4)
            begin n_fail++; $display("FAIL bp_hold i=%0d valid=%b data=%h busy=%b ready=%b exp 1/%h/1/0", i, bus.out_valid, bus.out_data, bus.busy, bus.in_ready, exp_d); end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick();
      n_hs++;
      tick();
      n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.round_o !== 3'd0)
         begin n_fail++; $display("FAIL bp_release ready=%b valid=%b round=%0d exp 1/0/0", bus.in_ready, bus.out_valid, bus.round_o); end
   endtask

   task automatic test_toggle_inputs();
      for (int t = 0; t < 8; t++) begin
         bit ok; int cyc = 0; bit m = 1'($urandom_range(0, 1));
         bit [15:0] d = 16'($urandom); bit [31:0] k = $urandom; bit [15:0] exp_d;
         exp_d = m ? m_dec(d, k) : m_enc(d, k);
         send(m, d, k, ok);
         while (!bus.out_valid && cyc < 20) begin
            bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = 16'($urandom);
            bus.in_key = $urandom; bus.in_mode = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(); cyc++;
         end
         bus.in_valid = 1'b0; bus.out_ready = 1'b1;
         n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL toggle_latency got %0d exp 4", cyc); end
         n_tests++; if (bus.out_data !== exp_d) begin n_fail++; $display("FAIL toggle_result got %h exp %h", bus.out_data, exp_d); end
         tick();
         n_hs++;
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok; int cyc; bit [15:0] got; bit [15:0] p = 16'($urandom); bit [31:0] k = $urandom;
      bus.out_ready = 1'b1;
      send(0, p, k, ok);
      tick();
      n_tests++; if (bus.round_o !== 3'd2) begin n_fail++; $display("FAIL mid_round got %0d exp 2", bus.round_o); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round_o !== 3'd0 || bus.out_data !== 16'h0)
         begin n_fail++; $display("FAIL mid_rst_outs ready=%b valid=%b busy=%b round=%0d data=%h exp 1/0/0/0/0000", bus.in_ready, bus.out_valid, bus.busy, bus.round_o, bus.out_data); end
      tick();
      rst_n = 1'b1;
      n_acc--;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL spurious_after_run valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
      end
      // reset while a result waits in DONE
      bus.out_ready = 1'b0;
      send(1, p, k, ok);
      wait_valid(cyc);
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin n_fail++; $display("FAIL done_rst valid=%b data=%h exp 0/0000", bus.out_valid, bus.out_data); end
      tick();
      rst_n = 1'b1;
      n_acc--;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_after_done valid=%b exp 0", bus.out_valid); end
      end
      run_one(0, p, k, got, ok);
      n_tests++; if (!ok || got !== m_enc(p, k)) begin n_fail++; $display("FAIL post_rst_block ok=%b got %h exp %h", ok, got, m_enc(p, k)); end
   endtask

   task automatic test_random_roundtrip();
      bit [15:0] q[$];
      for (int i = 0; i < 2500; i++) begin
         bit ok; bit [15:0] c; bit [15:0] d; bit [15:0] exp_c;
         bit [15:0] p = 16'($urandom); bit [31:0] k = $urandom;
         q.push_back(m_enc(p, k));
         run_one(0, p, k, c, ok);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL rnd_enc_timeout i=%0d out_valid=%b exp handshake", i, bus.out_valid); end
         else begin
            exp_c = q.pop_front();
            if (c !== exp_c) begin n_fail++; $display("FAIL rnd_enc i=%0d p=%h k=%h got %h exp %h", i, p, k, c, exp_c); end
         end
         run_one(1, c, k, d, ok);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL rnd_dec_timeout i=%0d out_valid=%b exp handshake", i, bus.out_valid); end
         else if (d !== p) begin n_fail++; $display("FAIL rnd_roundtrip i=%0d k=%h c=%h got %h exp %h", i, k, c, d, p); end
      end
      n_tests++; if (n_hs !== n_acc) begin n_fail++; $display("FAIL result_count got %0d exp %0d", n_hs, n_acc); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) sinv_tab[sbox_tab[i]] = 4'(i);
      test_reset();
      test_enc_vector();
      test_dec_vector();
      test_backpressure();
      test_toggle_inputs();
      test_reset_mid_run();
      test_random_roundtrip();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
